// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and default sizes for the register-file write arbiter.
// Contents: default width constants, the source-select enum, the write-request
// payload struct, and a power-of-two helper used for parameter checks.
package regfile_write_arbiter_pkg;

  localparam int unsigned ARB_ADDRESS_WIDTH = 5;
  localparam int unsigned ARB_DATA_WIDTH    = 32;
  localparam int unsigned ARB_FIFO_DEPTH    = 4;
  localparam int unsigned ARB_STARVE_LIMIT  = 8;

  // Which source drives the write port in a given cycle
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_WB,
    SRC_FIFO,
    SRC_BYPASS
  } src_e;

  // Write request at the default widths
  typedef struct packed {
    logic                         valid;
    logic [ARB_ADDRESS_WIDTH-1:0] addr;
    logic [ARB_DATA_WIDTH-1:0]    data;
  } wr_req_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_result_fifo.sv
// result_fifo: synchronous FIFO buffering multicycle results.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write one entry (caller never pushes when full)
//   pop             drop the head entry (caller never pops when empty)
//   head_c          current head entry (combinational from state)
//   full_c, empty_c status derived from the registered count
//   count           number of stored entries, 0..DEPTH
module result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 37
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head_c  = mem[rd_ptr];
  assign full_c  = (count == CW'(DEPTH));
  assign empty_c = (count == '0);

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: merges pipeline writeback and buffered multicycle
// results onto the register file's single write port, and tracks registers
// with an outstanding multicycle write.
// Ports:
//   iClk, iRst                     clock, synchronous active-high reset
//   iWbValid/iWbAddr/iWbData       pipeline writeback (highest priority)
//   iMcValid/iMcAddr/iMcData       multicycle result offer
//   oMcReady                       multicycle accept (combinational from count)
//   iIssueValid/iIssueAddr         multicycle issue, marks destination busy
//   oWriteEn/oWriteAddress/oDataOut registered register-file write port
//   oBusy                          per-register pending-write scoreboard
//   oStallWb                       starvation request to freeze writeback
// Optional: define ARB_STARVE_GUARD_EN to build the starvation guard;
// otherwise oStallWb is tied low.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = ARB_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = ARB_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH    = ARB_FIFO_DEPTH,
  parameter int unsigned STARVE_LIMIT  = ARB_STARVE_LIMIT
) (
  input  logic                        iClk,
  input  logic                        iRst,
  input  logic                        iWbValid,
  input  logic [ADDRESS_WIDTH-1:0]    iWbAddr,
  input  logic [DATA_WIDTH-1:0]       iWbData,
  input  logic                        iMcValid,
  input  logic [ADDRESS_WIDTH-1:0]    iMcAddr,
  input  logic [DATA_WIDTH-1:0]       iMcData,
  output logic                        oMcReady,
  input  logic                        iIssueValid,
  input  logic [ADDRESS_WIDTH-1:0]    iIssueAddr,
  output logic                        oWriteEn,
  output logic [ADDRESS_WIDTH-1:0]    oWriteAddress,
  output logic [DATA_WIDTH-1:0]       oDataOut,
  output logic [2**ADDRESS_WIDTH-1:0] oBusy,
  output logic                        oStallWb
);

  localparam int unsigned REGS = 2**ADDRESS_WIDTH;
  localparam int unsigned PW   = ADDRESS_WIDTH + DATA_WIDTH;
  localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;

  if (!is_pow2(FIFO_DEPTH) || (FIFO_DEPTH < 2)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  typedef struct packed {
    logic                     valid;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    data;
  } req_t;

  logic [PW-1:0] fifo_head_c;
  logic          fifo_full_c;
  logic          fifo_empty_c;
  logic [CW-1:0] fifo_count;
  logic          fifo_push_c;
  logic          fifo_pop_c;
  src_e          src_c;
  req_t          sel_c;
  logic [REGS-1:0] busy_nxt_c;

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PW)
  ) u_fifo (
    .clk       (iClk),
    .rst       (iRst),
    .push      (fifo_push_c),
    .push_data ({iMcAddr, iMcData}),
    .pop       (fifo_pop_c),
    .head_c    (fifo_head_c),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c),
    .count     (fifo_count)
  );

  // No pop-through: a full FIFO stays not-ready even while it pops
  assign oMcReady = (fifo_count < CW'(FIFO_DEPTH));

  // Source selection; bypass only when the FIFO is empty to keep order
  always_comb begin
    src_c       = SRC_NONE;
    sel_c       = '0;
    fifo_pop_c  = 1'b0;
    if (iWbValid) begin
      src_c = SRC_WB;
      sel_c = '{valid: 1'b1, addr: iWbAddr, data: iWbData};
    end else if (!fifo_empty_c) begin
      src_c      = SRC_FIFO;
      fifo_pop_c = 1'b1;
      sel_c      = '{valid: 1'b1,
                     addr:  fifo_head_c[PW-1:DATA_WIDTH],
                     data:  fifo_head_c[DATA_WIDTH-1:0]};
    end else if (iMcValid) begin
      src_c = SRC_BYPASS;
      sel_c = '{valid: 1'b1, addr: iMcAddr, data: iMcData};
    end
    fifo_push_c = iMcValid && !fifo_full_c && (src_c != SRC_BYPASS);
  end

  // Scoreboard: MC writes clear as they issue to the port; a new issue wins
  always_comb begin
    busy_nxt_c = oBusy;
    if ((src_c == SRC_FIFO) || (src_c == SRC_BYPASS)) begin
      busy_nxt_c[sel_c.addr] = 1'b0;
    end
    if (iIssueValid && (iIssueAddr != '0)) begin
      busy_nxt_c[iIssueAddr] = 1'b1;
    end
  end

  // Registered write port; x0 writes are consumed but never enabled
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oWriteEn      <= 1'b0;
      oWriteAddress <= '0;
      oDataOut      <= '0;
      oBusy         <= '0;
    end else begin
      oWriteEn <= sel_c.valid && (sel_c.addr != '0);
      if (sel_c.valid) begin
        oWriteAddress <= sel_c.addr;
        oDataOut      <= sel_c.data;
      end
      oBusy <= busy_nxt_c;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          stall_q;

  // Counts cycles the FIFO head is blocked by writeback; saturates at limit
  always_ff @(posedge iClk) begin
    if (iRst) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else if (fifo_pop_c) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else if (!fifo_empty_c && iWbValid && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + SW'(1);
      if ((starve_cnt + SW'(1)) == SW'(STARVE_LIMIT)) stall_q <= 1'b1;
    end
  end

  assign oStallWb = stall_q;
`else
  assign oStallWb = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iWbValid;
  logic [4:0]  iWbAddr;
  logic [31:0] iWbData;
  logic        iMcValid;
  logic [4:0]  iMcAddr;
  logic [31:0] iMcData;
  logic        oMcReady;
  logic        iIssueValid;
  logic [4:0]  iIssueAddr;
  logic        oWriteEn;
  logic [4:0]  oWriteAddress;
  logic [31:0] oDataOut;
  logic [31:0] oBusy;
  logic        oStallWb;

  int tests = 0;
  int fails = 0;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  regfile_write_arbiter dut (
    .iClk          (iClk),
    .iRst          (iRst),
    .iWbValid      (iWbValid),
    .iWbAddr       (iWbAddr),
    .iWbData       (iWbData),
    .iMcValid      (iMcValid),
    .iMcAddr       (iMcAddr),
    .iMcData       (iMcData),
    .oMcReady      (oMcReady),
    .iIssueValid   (iIssueValid),
    .iIssueAddr    (iIssueAddr),
    .oWriteEn      (oWriteEn),
    .oWriteAddress (oWriteAddress),
    .oDataOut      (oDataOut),
    .oBusy         (oBusy),
    .oStallWb      (oStallWb)
  );

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic en, input logic [4:0] addr,
                          input logic [31:0] data);
    check({tag, ".en"}, 64'(oWriteEn), 64'(en));
    if (en) begin
      check({tag, ".addr"}, 64'(oWriteAddress), 64'(addr));
      check({tag, ".data"}, 64'(oDataOut), 64'(data));
    end
  endtask

  task automatic idle();
    iWbValid = 0; iWbAddr = '0; iWbData = '0;
    iMcValid = 0; iMcAddr = '0; iMcData = '0;
    iIssueValid = 0; iIssueAddr = '0;
  endtask

  initial begin
    idle();
    iRst = 1'b1;
    tick();
    tick();
    iRst = 1'b0;

    // Reset state
    check_wr("rst", 1'b0, 5'd0, 32'd0);
    check("rst.addr", 64'(oWriteAddress), 64'd0);
    check("rst.data", 64'(oDataOut), 64'd0);
    check("rst.busy", 64'(oBusy), 64'd0);
    check("rst.ready", 64'(oMcReady), 64'd1);
    check("rst.stall", 64'(oStallWb), 64'd0);

    // Bypass clears a busy register
    iIssueValid = 1; iIssueAddr = 5'd5;
    tick();
    check("byp.busy_set", 64'(oBusy), 64'h20);
    idle();
    iMcValid = 1; iMcAddr = 5'd5; iMcData = 32'hDEADBEEF;
    tick();
    check_wr("byp.wr", 1'b1, 5'd5, 32'hDEADBEEF);
    check("byp.busy_clr", 64'(oBusy), 64'h0);
    idle();
    tick();
    check_wr("byp.idle", 1'b0, 5'd0, 32'd0);

    // WB priority, MC result follows from the FIFO
    iWbValid = 1; iWbAddr = 5'd3; iWbData = 32'h11;
    iMcValid = 1; iMcAddr = 5'd4; iMcData = 32'h22;
    tick();
    check_wr("prio.wb", 1'b1, 5'd3, 32'h11);
    idle();
    tick();
    check_wr("prio.mc", 1'b1, 5'd4, 32'h22);
    tick();
    check_wr("prio.idle", 1'b0, 5'd0, 32'd0);

    // Full FIFO under continuous writeback
    for (int i = 0; i < 4; i++) begin
      iWbValid = 1; iWbAddr = 5'd1; iWbData = 32'h100 + 32'(i);
      iMcValid = 1; iMcAddr = 5'(8 + i); iMcData = 32'hA0 + 32'(i);
      tick();
      check_wr("full.wb", 1'b1, 5'd1, 32'h100 + 32'(i));
    end
    check("full.ready0", 64'(oMcReady), 64'd0);
    iWbData = 32'h104; iMcAddr = 5'd12; iMcData = 32'hA4;
    tick();
    check_wr("full.wb5", 1'b1, 5'd1, 32'h104);
    check("full.ready_still0", 64'(oMcReady), 64'd0);
    idle();
    tick();
    check_wr("full.d0", 1'b1, 5'd8, 32'hA0);
    check("full.ready_after_pop", 64'(oMcReady), 64'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check_wr("full.drain", 1'b1, 5'(8 + i), 32'hA0 + 32'(i));
    end
    tick();
    check_wr("full.no_5th", 1'b0, 5'd0, 32'd0);

    // Scoreboard set-wins, x0 handling, WB does not clear
    iIssueValid = 1; iIssueAddr = 5'd7;
    iMcValid = 1; iMcAddr = 5'd7; iMcData = 32'h77;
    tick();
    check_wr("sb.mc7", 1'b1, 5'd7, 32'h77);
    check("sb.set_wins", 64'(oBusy), 64'h80);
    idle();
    iIssueValid = 1; iIssueAddr = 5'd0;
    iMcValid = 1; iMcAddr = 5'd0; iMcData = 32'h55;
    tick();
    check_wr("sb.x0_write", 1'b0, 5'd0, 32'd0);
    check("sb.x0_busy", 64'(oBusy), 64'h80);
    idle();
    iWbValid = 1; iWbAddr = 5'd7; iWbData = 32'h1;
    tick();
    check_wr("sb.wb7", 1'b1, 5'd7, 32'h1);
    check("sb.wb_no_clear", 64'(oBusy), 64'h80);
    idle();
    iMcValid = 1; iMcAddr = 5'd7; iMcData = 32'h78;
    tick();
    check("sb.mc_clear", 64'(oBusy), 64'h0);
    idle();
    tick();

    // Reset mid-stream discards queued entries and busy bits
    iWbValid = 1; iWbAddr = 5'd2; iWbData = 32'h2;
    iIssueValid = 1; iIssueAddr = 5'd9;
    iMcValid = 1; iMcAddr = 5'd13; iMcData = 32'hC0;
    tick();
    iIssueValid = 0;
    iMcAddr = 5'd14; iMcData = 32'hC1;
    tick();
    iMcAddr = 5'd15; iMcData = 32'hC2;
    tick();
    check("rstm.busy_pre", 64'(oBusy), 64'h200);
    idle();
    iRst = 1'b1;
    tick();
    iRst = 1'b0;
    check_wr("rstm.wr", 1'b0, 5'd0, 32'd0);
    check("rstm.busy", 64'(oBusy), 64'd0);
    check("rstm.ready", 64'(oMcReady), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_wr("rstm.no_stale", 1'b0, 5'd0, 32'd0);
    end

    // Starvation: one queued entry blocked by 8 writeback cycles
    iWbValid = 1; iWbAddr = 5'd1; iWbData = 32'h5;
    iMcValid = 1; iMcAddr = 5'd6; iMcData = 32'h66;
    tick();
    iMcValid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("guard.stall", 64'(oStallWb), 64'(GUARD && (i == 7)));
    end
    iWbValid = 0;
    tick();
    check_wr("guard.pop", 1'b1, 5'd6, 32'h66);
    check("guard.release", 64'(oStallWb), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Write-side front end of the 32x32 register file.
- Merges two result sources into the register file's single write port:
  - the in-order pipeline writeback stage, which has priority and never stalls;
  - a variable-latency multicycle unit (divider / late load return), buffered in a small FIFO.
- Keeps a per-register pending scoreboard so decode can stall on registers whose multicycle result has not yet been written.

Parameters:
- ADDRESS_WIDTH, 5, register address width; the register count is 2**ADDRESS_WIDTH.
- DATA_WIDTH, 32, register data width.
- FIFO_DEPTH, 4, number of multicycle result entries; must be a power of 2 and at least 2.
- STARVE_LIMIT, 8, consecutive blocked cycles before the guard fires (used only with the optional feature).

Ports:
- iClk  in  1  clock; all state updates on posedge.
- iRst  in  1  synchronous, active-high reset.
- iWbValid  in  1  pipeline writeback result valid this cycle.
- iWbAddr  in  ADDRESS_WIDTH  pipeline destination register.
- iWbData  in  DATA_WIDTH  pipeline result.
- iMcValid  in  1  multicycle result offered.
- iMcAddr  in  ADDRESS_WIDTH  multicycle destination register.
- iMcData  in  DATA_WIDTH  multicycle result.
- oMcReady  out  1  multicycle result accepted when iMcValid && oMcReady.
- iIssueValid  in  1  a multicycle op is issued this cycle.
- iIssueAddr  in  ADDRESS_WIDTH  destination register of the issued op.
- oWriteEn  out  1  to register file write enable.
- oWriteAddress  out  ADDRESS_WIDTH  to register file write address.
- oDataOut  out  DATA_WIDTH  to register file write data.
- oBusy  out  2**ADDRESS_WIDTH  scoreboard; bit n=1 means register n has a pending multicycle write.
- oStallWb  out  1  request to freeze the pipeline writeback (starvation guard).

Behaviour:
- Reset (cycle after iRst high):
  - oWriteEn=0, oWriteAddress=0, oDataOut=0.
  - FIFO emptied (read/write pointers and count =0), oBusy=0, oStallWb=0, oMcReady=1.
  - Reset mid-operation discards queued entries and pending bits; no write is emitted on the reset cycle.
- Outputs are registered: a source selected in cycle N appears on oWrite* in cycle N+1 for exactly one cycle.
- Selection each cycle:
  - iWbValid=1: select the WB source.
  - else if the FIFO is non-empty: select the FIFO head and pop it.
  - else if iMcValid=1: bypass, selecting the MC input directly with no FIFO entry.
  - else: no write; oWriteEn=0.
- MC acceptance:
  - oMcReady = (count<FIFO_DEPTH); combinational from registered count only.
  - An accepted MC result that is not bypassed is pushed.
  - Simultaneous push and pop leaves count unchanged.
  - Full FIFO with a pop in the same cycle still keeps oMcReady=0 (no pop-through).
- Ordering: FIFO entries drain strictly in acceptance order; bypass only occurs when the FIFO is empty.
- Address 0: any selected write with address 0 produces oWriteEn=0 (data dropped) but still pops/consumes normally.
- Scoreboard:
  - Set bit iIssueAddr on iIssueValid (never for address 0).
  - Clear bit a when an MC-sourced write to a reaches oWrite* (the cycle oWriteEn rises for it).
  - Same-address set and clear in one cycle: set wins.
  - Only MC writes clear bits; a WB write to a busy register does not clear it.
- Wrap-around: pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- With the macro:
  - A starve counter increments each cycle the FIFO is non-empty and iWbValid=1, and resets to 0 on any FIFO pop or on reset.
  - When the counter reaches STARVE_LIMIT, oStallWb=1 (registered); it holds until the next FIFO pop, then the counter clears.
  - The pipeline guarantees iWbValid=0 while oStallWb=1.
- Without the macro: no counter; oStallWb is tied 0.

Decomposition:
- Shared package:
  - write-request struct {valid, addr, data};
  - source enum {SRC_NONE, SRC_WB, SRC_FIFO, SRC_BYPASS};
  - default width constants.
- Sub-module result_fifo: a parameterised synchronous FIFO with push/pop/full/empty/count. The top level holds selection, the scoreboard and the guard.

Test Plan:
- Reset mid-stream:
  - Stimulus: push 3 MC entries, then assert iRst for 1 cycle.
  - Response: next cycle oWriteEn=0, oBusy=0, oMcReady=1, and no stale writes follow.
- Bypass:
  - Stimulus: FIFO empty, iWbValid=0, iMcValid=1, addr 5, data 0xDEADBEEF, with bit 5 busy.
  - Response: next cycle oWriteEn=1, oWriteAddress=5, oDataOut=0xDEADBEEF, oBusy[5]=0.
- Priority:
  - Stimulus: iWbValid=1 (addr 3, 0x11) and iMcValid=1 (addr 4, 0x22) in the same cycle.
  - Response: write x3=0x11, then write x4=0x22 the cycle after.
- Full FIFO:
  - Stimulus: hold iWbValid=1 and offer 5 MC results.
  - Response: 4 accepted, oMcReady=0 on the 5th; drained in order once iWbValid drops.
- x0 and scoreboard:
  - Stimulus: issue addr 0 and addr 7 in the same cycle as an MC write to 7.
  - Response: oBusy[0] never set; oBusy[7] stays 1 (set wins); an MC write with addr 0 gives oWriteEn=0.
- Guard (ARB_STARVE_GUARD_EN):
  - Stimulus: FIFO non-empty with iWbValid=1 for 8 cycles.
  - Response: oStallWb=1 in cycle 9, deasserted the cycle after the pop.
